// File: rtl/ahb_arbiter.sv
// ----------------------------------------------------------------------------
// ahb_arbiter
//
// Round-robin arbiter for a shared AHB address/data path. It grants one master
// at a time, tracks fixed-length bursts and locked sequences, and only moves
// ownership at a legal transfer boundary (an "arbitration point").
//
// Ports:
//   HCLK          bus clock; all state changes on the rising edge
//   HRESET        asynchronous active-high reset
//   HBUSREQ[N]    per-master bus request
//   HLOCK[N]      per-master locked-access request
//   HTRANS[2]     transfer type of the current address-phase owner
//   HBURST[3]     burst type of the current address-phase owner
//   HREADY        bus ready from the slave response mux
//   HGRANT[N]     one-hot grant, registered, always equals one-hot(HMASTER)
//   HMASTER[MW]   index of the address-phase owner, registered
//   HMASTER_DATA  index of the data-phase owner (HMASTER one beat later)
//   HMASTLOCK     current address-phase owner holds a locked sequence
//
// Handshake: a rising edge with HREADY=1 is an accepted beat; every piece of
// state here (grant, owner, data-phase owner, beat counter, lock) advances
// only on accepted beats. An edge with HREADY=0 is a wait state and leaves
// all state untouched.
// ----------------------------------------------------------------------------
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic [MW-1:0]          HMASTER_DATA,
    output logic                   HMASTLOCK
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;

    localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

    // Beats still to come after the current one in a fixed-length burst.
    logic [3:0] beats_rem;

    logic          arb_point;
    logic [MW-1:0] next_master;
    logic          found;
    logic [MW:0]   cand_sum;
    logic [MW-1:0] cand;

    // Remaining beats after the NONSEQ beat (0 for SINGLE and undefined INCR).
    function automatic logic [3:0] burst_last(input logic [2:0] burst);
        case (burst)
            3'b010, 3'b011: burst_last = 4'd3;
            3'b100, 3'b101: burst_last = 4'd7;
            3'b110, 3'b111: burst_last = 4'd15;
            default:        burst_last = 4'd0;
        endcase
    endfunction

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [MW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Ownership may move only at the end of a transfer that is not inside a
    // protected fixed-length burst. BUSY never qualifies.
    always_comb begin
        arb_point = 1'b0;
        if (HREADY) begin
            case (HTRANS)
                TRANS_IDLE:   arb_point = 1'b1;
                TRANS_NONSEQ: arb_point = (HBURST == BURST_SINGLE) ||
                                          (HBURST == BURST_INCR);
                TRANS_SEQ:    arb_point = (beats_rem == 4'd1) ||
                                          (HBURST == BURST_INCR);
                default:      arb_point = 1'b0;
            endcase
        end
    end

    // Round-robin search starting just after the current owner and ending on
    // the owner itself, so a lone requester that already owns the bus keeps
    // it. The sum is one bit wider than the index so the wrap compare works
    // for non-power-of-two master counts.
    always_comb begin
        next_master = DEF_IDX;
        found       = 1'b0;
        cand_sum    = '0;
        cand        = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand_sum = {1'b0, HMASTER} + (MW+1)'(i);
            if (cand_sum >= (MW+1)'(NUM_MASTERS)) begin
                cand_sum = cand_sum - (MW+1)'(NUM_MASTERS);
            end
            cand = cand_sum[MW-1:0];
            if (!found && HBUSREQ[cand]) begin
                next_master = cand;
                found       = 1'b1;
            end
        end
        // A held lock overrides any competing request.
        if (HMASTLOCK && HLOCK[HMASTER]) begin
            next_master = HMASTER;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            HGRANT       <= onehot(DEF_IDX);
            HMASTER      <= DEF_IDX;
            HMASTER_DATA <= DEF_IDX;
            HMASTLOCK    <= 1'b0;
            beats_rem    <= 4'd0;
        end else if (HREADY) begin
            // Data phase follows the address phase that was just accepted.
            HMASTER_DATA <= HMASTER;

            case (HTRANS)
                TRANS_NONSEQ: beats_rem <= burst_last(HBURST);
                TRANS_SEQ:    beats_rem <= (beats_rem == 4'd0) ? 4'd0 : beats_rem - 4'd1;
                TRANS_IDLE:   beats_rem <= 4'd0;
                TRANS_BUSY:   beats_rem <= beats_rem;
                default:      beats_rem <= beats_rem;
            endcase

            if (arb_point) begin
                HMASTER   <= next_master;
                HGRANT    <= onehot(next_master);
                HMASTLOCK <= HLOCK[next_master] & HBUSREQ[next_master];
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ahb_arbiter
//
// Directed bench for ahb_arbiter (4 masters, default master 0). A table of
// per-cycle input/expected-output records walks through round-robin order,
// fixed-burst protection, wait states, locking, parking and BUSY beats. Hand
// sequences cover asynchronous reset at start and in the middle of a burst.
// ----------------------------------------------------------------------------
module tb_ahb_arbiter;

    localparam int N = 4;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] NSEQ = 2'b10;
    localparam logic [1:0] SEQ  = 2'b11;

    localparam logic [2:0] SGL   = 3'b000;
    localparam logic [2:0] INCR  = 3'b001;
    localparam logic [2:0] INCR4 = 3'b011;
    localparam logic [2:0] INCR8 = 3'b101;

    // ---------------- clock / reset ----------------
    logic         HCLK = 1'b0;
    logic         HRESET;
    logic [N-1:0] HBUSREQ;
    logic [N-1:0] HLOCK;
    logic [1:0]   HTRANS;
    logic [2:0]   HBURST;
    logic         HREADY;
    logic [N-1:0] HGRANT;
    logic [1:0]   HMASTER;
    logic [1:0]   HMASTER_DATA;
    logic         HMASTLOCK;

    always #5 HCLK = ~HCLK;

    ahb_arbiter #(
        .NUM_MASTERS    (N),
        .DEFAULT_MASTER (0)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .HBUSREQ      (HBUSREQ),
        .HLOCK        (HLOCK),
        .HTRANS       (HTRANS),
        .HBURST       (HBURST),
        .HREADY       (HREADY),
        .HGRANT       (HGRANT),
        .HMASTER      (HMASTER),
        .HMASTER_DATA (HMASTER_DATA),
        .HMASTLOCK    (HMASTLOCK)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] lock;
        logic [1:0]   trans;
        logic [2:0]   burst;
        logic         rdy;
        int           exp_m;
        int           exp_md;
        int           exp_lk;
        int           exp_br;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [N-1:0] req, input logic [N-1:0] lock,
                                input logic [1:0] trans, input logic [2:0] burst,
                                input logic rdy, input int m, input int md,
                                input int lk, input int br);
        vec_t v;
        v.req = req; v.lock = lock; v.trans = trans; v.burst = burst; v.rdy = rdy;
        v.exp_m = m; v.exp_md = md; v.exp_lk = lk; v.exp_br = br;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int m, input int md,
                             input int lk, input int br);
        check({tag, " hmaster"},      int'(HMASTER),       m);
        check({tag, " hmaster_data"}, int'(HMASTER_DATA),  md);
        check({tag, " hmastlock"},    int'(HMASTLOCK),     lk);
        check({tag, " hgrant"},       int'(HGRANT),        1 << m);
        check({tag, " beats_rem"},    int'(dut.beats_rem), br);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lock,
                         input logic [1:0] trans, input logic [2:0] burst,
                         input logic rdy);
        HBUSREQ = req;
        HLOCK   = lock;
        HTRANS  = trans;
        HBURST  = burst;
        HREADY  = rdy;
    endtask

    // Apply inputs, take one edge, sample 1 time unit later.
    task automatic step(input vec_t v);
        drive(v.req, v.lock, v.trans, v.burst, v.rdy);
        @(posedge HCLK);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main ----------------
    initial begin
        // Round-robin order, owners 0,1,2,3,0 then 1
        vecs.push_back(mk(4'hF, 4'h0, NSEQ, SGL,   1'b1, 1, 0, 0, 0));
        vecs.push_back(mk(4'hF, 4'h0, NSEQ, SGL,   1'b1, 2, 1, 0, 0));
        vecs.push_back(mk(4'hF, 4'h0, NSEQ, SGL,   1'b1, 3, 2, 0, 0));
        vecs.push_back(mk(4'hF, 4'h0, NSEQ, SGL,   1'b1, 0, 3, 0, 0));
        vecs.push_back(mk(4'hF, 4'h0, NSEQ, SGL,   1'b1, 1, 0, 0, 0));
        // Master 1 INCR4: held for 4 beats, handover on the 4th
        vecs.push_back(mk(4'hF, 4'h0, NSEQ, INCR4, 1'b1, 1, 1, 0, 3));
        vecs.push_back(mk(4'hF, 4'h0, SEQ,  INCR4, 1'b1, 1, 1, 0, 2));
        vecs.push_back(mk(4'hF, 4'h0, SEQ,  INCR4, 1'b1, 1, 1, 0, 1));
        vecs.push_back(mk(4'hF, 4'h0, SEQ,  INCR4, 1'b1, 2, 1, 0, 0));
        // Master 2 INCR4 with a 3-cycle stall on beat 2
        vecs.push_back(mk(4'hF, 4'h0, NSEQ, INCR4, 1'b1, 2, 2, 0, 3));
        vecs.push_back(mk(4'hF, 4'h0, SEQ,  INCR4, 1'b0, 2, 2, 0, 3));
        vecs.push_back(mk(4'hF, 4'h0, SEQ,  INCR4, 1'b0, 2, 2, 0, 3));
        vecs.push_back(mk(4'hF, 4'h0, SEQ,  INCR4, 1'b0, 2, 2, 0, 3));
        vecs.push_back(mk(4'hF, 4'h0, SEQ,  INCR4, 1'b1, 2, 2, 0, 2));
        vecs.push_back(mk(4'hF, 4'h0, SEQ,  INCR4, 1'b1, 2, 2, 0, 1));
        vecs.push_back(mk(4'hF, 4'h0, SEQ,  INCR4, 1'b1, 3, 2, 0, 0));
        // Master 2 takes a lock, keeps the bus for 3 SINGLEs, then releases
        vecs.push_back(mk(4'h4, 4'h4, IDLE, SGL,   1'b1, 2, 3, 1, 0));
        vecs.push_back(mk(4'hF, 4'h4, NSEQ, SGL,   1'b1, 2, 2, 1, 0));
        vecs.push_back(mk(4'hF, 4'h4, NSEQ, SGL,   1'b1, 2, 2, 1, 0));
        vecs.push_back(mk(4'hF, 4'h4, NSEQ, SGL,   1'b1, 2, 2, 1, 0));
        vecs.push_back(mk(4'hF, 4'h0, NSEQ, SGL,   1'b1, 3, 2, 0, 0));
        // No requests: park on default master
        vecs.push_back(mk(4'h0, 4'h0, IDLE, SGL,   1'b1, 0, 3, 0, 0));
        // Master 0 INCR8 with BUSY beats inserted
        vecs.push_back(mk(4'hF, 4'h0, NSEQ, INCR8, 1'b1, 0, 0, 0, 7));
        vecs.push_back(mk(4'hF, 4'h0, BUSY, INCR8, 1'b1, 0, 0, 0, 7));
        vecs.push_back(mk(4'hF, 4'h0, SEQ,  INCR8, 1'b1, 0, 0, 0, 6));
        vecs.push_back(mk(4'hF, 4'h0, BUSY, INCR8, 1'b1, 0, 0, 0, 6));
        vecs.push_back(mk(4'hF, 4'h0, SEQ,  INCR8, 1'b1, 0, 0, 0, 5));
        vecs.push_back(mk(4'hF, 4'h0, SEQ,  INCR8, 1'b1, 0, 0, 0, 4));
        vecs.push_back(mk(4'hF, 4'h0, SEQ,  INCR8, 1'b1, 0, 0, 0, 3));
        vecs.push_back(mk(4'hF, 4'h0, SEQ,  INCR8, 1'b1, 0, 0, 0, 2));
        vecs.push_back(mk(4'hF, 4'h0, SEQ,  INCR8, 1'b1, 0, 0, 0, 1));
        vecs.push_back(mk(4'hF, 4'h0, SEQ,  INCR8, 1'b1, 1, 0, 0, 0));
        // Undefined INCR bursts may be broken on any beat
        vecs.push_back(mk(4'hF, 4'h0, NSEQ, INCR,  1'b1, 2, 1, 0, 0));
        vecs.push_back(mk(4'hF, 4'h0, SEQ,  INCR,  1'b1, 3, 2, 0, 0));
        // Lone requester that already owns the bus keeps it
        vecs.push_back(mk(4'h8, 4'h0, IDLE, SGL,   1'b1, 3, 3, 0, 0));

        // Reset asserted mid-cycle with everyone requesting
        HRESET = 1'b0;
        drive(4'hF, 4'h0, NSEQ, SGL, 1'b1);
        #3;
        HRESET = 1'b1;
        #1;
        check_all("reset_async", 0, 0, 0, 0);
        @(posedge HCLK);
        #1;
        check_all("reset_held", 0, 0, 0, 0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        // Wait state right after release: nothing moves
        step(mk(4'hF, 4'h0, NSEQ, SGL, 1'b0, 0, 0, 0, 0));
        check_all("post_reset_stall", 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
            check_all($sformatf("vec%0d", i),
                      vecs[i].exp_m, vecs[i].exp_md, vecs[i].exp_lk, vecs[i].exp_br);
        end

        // Reset in the middle of a master-3 INCR4 burst
        step(mk(4'hF, 4'h8, NSEQ, INCR4, 1'b1, 3, 3, 0, 3));
        check_all("mid_burst_ns", 3, 3, 0, 3);
        step(mk(4'hF, 4'h8, SEQ, INCR4, 1'b1, 3, 3, 0, 2));
        check_all("mid_burst_seq", 3, 3, 0, 2);
        #2;
        HRESET = 1'b1;
        #1;
        check_all("mid_burst_reset", 0, 0, 0, 0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        step(mk(4'hF, 4'h8, SEQ, INCR4, 1'b0, 0, 0, 0, 0));
        check_all("mid_burst_after_stall", 0, 0, 0, 0);
        // First accepted beat after reset arbitrates from the default master
        step(mk(4'h2, 4'h0, IDLE, SGL, 1'b1, 1, 0, 0, 0));
        check_all("mid_burst_after_arb", 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Round-robin bus arbiter that shares the single AHB address/data path among NUM_MASTERS masters.
- Sits beside the decoder and slave response mux.
- Drives HGRANT/HMASTER, which select the master address/control mux.
- Drives HMASTER_DATA, which selects the write-data mux one phase later.
- Tracks fixed-length bursts and locked sequences so ownership changes only at legal transfer boundaries.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16)
DEFAULT_MASTER, 0, master parked on bus when nobody requests
MW, $clog2(NUM_MASTERS), width of master index (derived, not overridden)

Ports:
HCLK  input  1  bus clock, all state on rising edge
HRESET  input  1  asynchronous active-high reset
HBUSREQ  input  NUM_MASTERS  per-master bus request
HLOCK  input  NUM_MASTERS  per-master locked-access request
HTRANS  input  2  muxed transfer type of current address-phase owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
HBURST  input  3  muxed burst type of current owner
HREADY  input  1  muxed bus ready from response mux
HGRANT  output  NUM_MASTERS  one-hot grant, registered
HMASTER  output  MW  index of address-phase owner, registered
HMASTER_DATA  output  MW  index of data-phase owner, registered
HMASTLOCK  output  1  current address-phase owner holds a locked sequence

Behaviour:
Reset, asynchronous, active while HRESET=1:
- HGRANT = one-hot(DEFAULT_MASTER); HMASTER = HMASTER_DATA = DEFAULT_MASTER.
- HMASTLOCK = 0; beats_rem = 0.
- HRESET asserted mid-burst or mid-lock aborts immediately; first post-reset owner is DEFAULT_MASTER.

Accepted beat: a rising edge with HREADY=1. Edges with HREADY=0 change no state (grant, HMASTER, HMASTER_DATA, beats_rem all hold).

Burst length: SINGLE=1, INCR=undefined, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16.

beats_rem, 4-bit, updated on accepted beats only:
- NONSEQ: load len-1 (0 for SINGLE/INCR).
- SEQ: decrement, saturating at 0.
- IDLE: clear to 0.
- BUSY: hold.

Arbitration point: an accepted beat where any of the following holds:
- HTRANS=IDLE.
- HTRANS=NONSEQ and HBURST is SINGLE or INCR.
- HTRANS=SEQ and beats_rem==1, i.e. this is the last beat of a fixed burst.
- HTRANS=SEQ and HBURST=INCR (undefined bursts may be broken).

BUSY is never an arbitration point.

Next-owner selection, evaluated at an arbitration point:
- If HMASTLOCK=1 and HLOCK[HMASTER]=1, the owner is retained unconditionally.
- Otherwise, round-robin: search HBUSREQ starting at HMASTER+1, wrapping modulo NUM_MASTERS, ending at HMASTER itself. The first asserted request wins.
- If no request is asserted, park on DEFAULT_MASTER.
- A lone requester that is already the owner keeps the bus.

Update at an arbitration point:
- HMASTER <= next; HGRANT <= one-hot(next).
- HMASTLOCK <= HLOCK[next] & HBUSREQ[next].
- Grant takes effect for the address phase starting after that edge; there is no separate grant cycle.

Data-phase pipeline: on every accepted beat, HMASTER_DATA <= HMASTER (the pre-update value). HMASTER_DATA therefore lags HMASTER by exactly one accepted transfer.

Simultaneous events:
- Request deassert on the same edge as an arbitration point: evaluated on the sampled value.
- Lock deassert during a fixed burst does not cut the burst short.
- Lock release takes effect at the next arbitration point.

Invariants:
- HGRANT is always exactly one-hot and equals one-hot(HMASTER).
- HMASTER < NUM_MASTERS at all times.

Implementation size: 120-400 lines of RTL.

Test Plan:
1. Reset check: assert HRESET mid-cycle with HBUSREQ=4'b1111 -> immediately HGRANT=4'b0001, HMASTER=0, HMASTER_DATA=0, HMASTLOCK=0. These values hold until the first accepted beat after release.
2. Round-robin order: HBUSREQ=4'b1111, every owner issues one NONSEQ SINGLE, HREADY=1 -> HMASTER sequence 0,1,2,3,0 on successive edges; HMASTER_DATA sequence 0,0,1,2,3.
3. Fixed burst protection: master 1 owns the bus and issues INCR4 (NONSEQ, SEQ, SEQ, SEQ) with HBUSREQ=4'b1111 -> HMASTER stays 1 for all 4 beats and becomes 2 on the edge accepting the 4th beat.
4. Wait states: same INCR4, but HREADY=0 for 3 cycles on beat 2 -> HGRANT, HMASTER, HMASTER_DATA and beats_rem frozen during the stall; handover still occurs after beat 4.
5. Lock handling: master 2 sets HLOCK[2]=1 with HBUSREQ[2]=1 and issues 3 SINGLE transfers while others request -> HMASTER=2, HMASTLOCK=1 throughout. Lock drops -> next arbitration point grants master 3 and HMASTLOCK=0.
6. Park and BUSY: HBUSREQ=0 while master 3 owns the bus with HTRANS=IDLE -> HMASTER=DEFAULT_MASTER (0) next edge. During an INCR8 with BUSY cycles inserted, no handover on BUSY edges.
